if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a req/ack instruction-memory port that may take several cycles per fetch.
- Honours the MIPS branch delay slot, pipeline stall and exception flush.
- Presents registered if_pc/if_inst/if_valid to IF/ID, plus a stall request to the pipeline controller while a fetch is outstanding.

---
 rtl/if_fetch.sv | 189 ++++++++++++++++++
 tb/tb_if_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: MIPS instruction-fetch stage owning the PC, a req/ack instruction port and the IF/ID outputs.
// Optional macro IF_ADEL_CHECK_EN traps misaligned fetch addresses through if_adel_o.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stallreq_o,
  output logic        if_adel_o
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  logic        buf_valid_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_inst_q;
  logic [31:0] disc_addr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        if_valid_q;
  logic        adel_q;
  logic        adel_lock_q;

  logic        misaligned_s;
  logic        branch_take_s;
  logic [31:0] pc_next_d;

`ifdef IF_ADEL_CHECK_EN
  assign misaligned_s = (pc_q[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  // Next fetch address once the current word is accepted: a same-cycle branch wins over a pending one.
  always_comb begin
    branch_take_s = branch_flag_i & ~stall;
    if (branch_take_s) begin
      pc_next_d = branch_target_i;
    end else if (pend_valid_q) begin
      pc_next_d = pend_target_q;
    end else begin
      pc_next_d = pc_q + 32'd4;
    end
  end

  // Memory request: DISCARD keeps the old address on the bus until the stale ack arrives.
  always_comb begin
    inst_req_o  = 1'b0;
    inst_addr_o = pc_q;
    case (state_q)
      S_FETCH: begin
        inst_req_o  = ~misaligned_s;
        inst_addr_o = pc_q;
      end
      S_DISCARD: begin
        inst_req_o  = 1'b1;
        inst_addr_o = disc_addr_q;
      end
      S_HOLD: begin
        inst_req_o  = 1'b0;
        inst_addr_o = pc_q;
      end
      default: begin
        inst_req_o  = 1'b0;
        inst_addr_o = pc_q;
      end
    endcase
  end

  assign stallreq_o = inst_req_o & ~inst_ack_i;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;
  assign if_valid   = if_valid_q;
  assign if_adel_o  = adel_q;

  // Fetch state machine: PC, pending delay-slot redirect, stall buffer and registered IF/ID outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= 32'h0000_0000;
      buf_inst_q    <= 32'h0000_0000;
      disc_addr_q   <= 32'h0000_0000;
      if_pc_q       <= 32'h0000_0000;
      if_inst_q     <= NOP_INST;
      if_valid_q    <= 1'b0;
      adel_q        <= 1'b0;
      adel_lock_q   <= 1'b0;
    end else if (flush_i) begin
      if_inst_q    <= NOP_INST;
      if_valid_q   <= 1'b0;
      adel_q       <= 1'b0;
      adel_lock_q  <= 1'b0;
      pc_q         <= flush_pc_i;
      pend_valid_q <= 1'b0;
      buf_valid_q  <= 1'b0;
      if (inst_req_o && !inst_ack_i) begin
        state_q     <= S_DISCARD;
        disc_addr_q <= inst_addr_o;
      end else begin
        state_q <= S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (misaligned_s) begin
            // One faulting bubble, then the stage parks until a flush redirects it.
            if (!stall && !adel_lock_q) begin
              if_pc_q     <= pc_q;
              if_inst_q   <= NOP_INST;
              if_valid_q  <= 1'b0;
              adel_q      <= 1'b1;
              adel_lock_q <= 1'b1;
            end
          end else if (inst_ack_i) begin
            pc_q         <= pc_next_d;
            pend_valid_q <= 1'b0;
            if (!stall) begin
              if_pc_q    <= pc_q;
              if_inst_q  <= inst_rdata_i;
              if_valid_q <= 1'b1;
              adel_q     <= 1'b0;
            end else begin
              buf_pc_q    <= pc_q;
              buf_inst_q  <= inst_rdata_i;
              buf_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end
          end else if (!stall) begin
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
            adel_q     <= 1'b0;
            // The outstanding fetch is the delay slot; redirect after it lands.
            if (branch_flag_i) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= branch_target_i;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_pc_q     <= buf_pc_q;
            if_inst_q   <= buf_inst_q;
            if_valid_q  <= buf_valid_q;
            adel_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            state_q     <= S_FETCH;
            if (branch_flag_i) begin
              pc_q <= branch_target_i;
            end
          end
        end
        S_DISCARD: begin
          if (inst_ack_i) begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: memory responder with programmable latency plus an expected-PC scoreboard.
module tb_if_fetch;

  localparam logic [31:0] MAGIC = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stallreq_o;
  logic        if_adel_o;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  logic [31:0] exp_q[$];

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_ack_i(inst_ack_i), .inst_rdata_i(inst_rdata_i),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .stallreq_o(stallreq_o), .if_adel_o(if_adel_o)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge: score a freshly loaded instruction, then answer the memory port.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (rst && !stall && if_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (if_pc !== e || if_inst !== (e ^ MAGIC)) begin
        errors++;
        $display("FAIL scoreboard: if_pc=%h if_inst=%h, required pc=%h inst=%h", if_pc, if_inst, e, e ^ MAGIC);
      end
    end
    if (!rst || !inst_req_o) begin
      inst_ack_i = 1'b0;
      wait_cnt   = 0;
    end else if (wait_cnt >= mem_lat) begin
      inst_ack_i   = 1'b1;
      inst_rdata_i = inst_addr_o ^ MAGIC;
      wait_cnt     = 0;
    end else begin
      inst_ack_i = 1'b0;
      wait_cnt++;
    end
    #1;
  endtask

  task automatic do_reset(input int lat);
    mem_lat       = lat;
    stall         = 1'b0;
    branch_flag_i = 1'b0;
    flush_i       = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    flush_i = 1'b0; flush_pc_i = 32'h0; inst_ack_i = 1'b0; inst_rdata_i = 32'h0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0 || if_valid !== 1'b0 || if_adel_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: pc=%h inst=%h valid=%b adel=%b, required 0/0/0/0", if_pc, if_inst, if_valid, if_adel_o);
    end
    tick();
    rst = 1'b1;
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1/00000000", inst_req_o, inst_addr_o);
    end
  endtask

  task automatic test_zero_wait();
    do_reset(0);
    for (int p = 0; p < 8; p++) exp_q.push_back(32'(p * 4));
    tick();
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL zw_first_cycle: req=%b addr=%h valid=%b, required 1/00000000/0", inst_req_o, inst_addr_o, if_valid);
    end
    tick(); tick(); tick();
    checks++;
    if (if_pc !== 32'h8 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL zw_rate: if_pc=%h valid=%b, required 00000008/1", if_pc, if_valid);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL zw_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_wait_states();
    do_reset(2);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    repeat (4) tick();
    checks++;
    if (if_pc !== 32'h0 || if_valid !== 1'b1 || stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL ws_first: pc=%h valid=%b stallreq=%b, required 0/1/1", if_pc, if_valid, stallreq_o);
    end
    tick();
    checks++;
    if (stallreq_o !== 1'b1 || if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL ws_bubble: stallreq=%b valid=%b inst=%h pc=%h, required 1/0/0/0", stallreq_o, if_valid, if_inst, if_pc);
    end
    tick();
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL ws_ack_cycle: stallreq=%b, required 0", stallreq_o);
    end
    tick();
    checks++;
    if (if_pc !== 32'h4 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL ws_second: pc=%h valid=%b, required 00000004/1", if_pc, if_valid);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ws_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_branch_delay_slot();
    do_reset(1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    for (int i = 0; i < 50 && !(if_pc === 32'h8 && if_valid === 1'b1); i++) tick();
    checks++;
    if (inst_req_o !== 1'b1 || inst_ack_i !== 1'b0 || inst_addr_o !== 32'hC) begin
      errors++;
      $display("FAIL br_outstanding: req=%b ack=%b addr=%h, required 1/0/0000000c", inst_req_o, inst_ack_i, inst_addr_o);
    end
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    tick();
    branch_flag_i = 1'b0;
    checks++;
    if (inst_addr_o !== 32'hC) begin
      errors++;
      $display("FAIL br_slot_addr: addr=%h, required 0000000c", inst_addr_o);
    end
    for (int i = 0; i < 50 && !(if_pc === 32'hC && if_valid === 1'b1); i++) tick();
    checks++;
    if (inst_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL br_redirect: addr=%h, required 00000100", inst_addr_o);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL br_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall_buffer();
    do_reset(0);
    for (int p = 0; p < 8; p++) exp_q.push_back(32'(p * 4));
    for (int i = 0; i < 50 && !(if_pc === 32'h10 && if_valid === 1'b1); i++) tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (if_pc !== 32'h10 || if_valid !== 1'b1 || if_inst !== (32'h10 ^ MAGIC) || inst_req_o !== 1'b0) begin
        errors++;
        $display("FAIL st_frozen%0d: pc=%h valid=%b inst=%h req=%b, required 00000010/1/%h/0", k, if_pc, if_valid, if_inst, inst_req_o, 32'h10 ^ MAGIC);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (if_pc !== 32'h14 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL st_buffered: pc=%h valid=%b, required 00000014/1", if_pc, if_valid);
    end
    tick();
    checks++;
    if (if_pc !== 32'h18 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL st_resume: pc=%h valid=%b, required 00000018/1", if_pc, if_valid);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL st_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_flush_discard();
    do_reset(3);
    exp_q.push_back(32'h0); exp_q.push_back(32'h380); exp_q.push_back(32'h384);
    for (int i = 0; i < 50 && !(if_pc === 32'h0 && if_valid === 1'b1); i++) tick();
    checks++;
    if (inst_req_o !== 1'b1 || inst_ack_i !== 1'b0) begin
      errors++;
      $display("FAIL fl_outstanding: req=%b ack=%b, required 1/0", inst_req_o, inst_ack_i);
    end
    flush_i = 1'b1; flush_pc_i = 32'h380;
    tick();
    flush_i = 1'b0;
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h4 || if_valid !== 1'b0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL fl_discard: req=%b addr=%h valid=%b inst=%h, required 1/00000004/0/0", inst_req_o, inst_addr_o, if_valid, if_inst);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fl_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset(0);
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFF8;
    tick();
    flush_i = 1'b0;
    checks++;
    if (inst_addr_o !== 32'hFFFF_FFF8 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_flush_ack: addr=%h valid=%b, required fffffff8/0", inst_addr_o, if_valid);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wr_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset(3);
    for (int i = 0; i < 50 && !(if_pc === 32'h4 && if_valid === 1'b1); i++) tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (if_pc !== 32'h0 || if_valid !== 1'b0 || if_inst !== 32'h0 || if_adel_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: pc=%h valid=%b inst=%h adel=%b, required 0/0/0/0", if_pc, if_valid, if_inst, if_adel_o);
    end
    tick();
    rst = 1'b1;
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rm_first_req: req=%b addr=%h, required 1/00000000", inst_req_o, inst_addr_o);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rm_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_misaligned_target();
    do_reset(0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
`ifdef IF_ADEL_CHECK_EN
    exp_q.push_back(32'h200);
`else
    exp_q.push_back(32'h102); exp_q.push_back(32'h106);
`endif
    for (int i = 0; i < 50 && !(if_pc === 32'h8 && if_valid === 1'b1); i++) tick();
    branch_flag_i = 1'b1; branch_target_i = 32'h102;
    tick();
    branch_flag_i = 1'b0;
`ifdef IF_ADEL_CHECK_EN
    checks++;
    if (inst_req_o !== 1'b0) begin
      errors++;
      $display("FAIL ad_no_req: req=%b, required 0", inst_req_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (if_adel_o !== 1'b1 || if_pc !== 32'h102 || if_valid !== 1'b0 || inst_req_o !== 1'b0) begin
        errors++;
        $display("FAIL ad_trap%0d: adel=%b pc=%h valid=%b req=%b, required 1/00000102/0/0", k, if_adel_o, if_pc, if_valid, inst_req_o);
      end
    end
    flush_i = 1'b1; flush_pc_i = 32'h200;
    tick();
    flush_i = 1'b0;
    checks++;
    if (if_adel_o !== 1'b0 || inst_req_o !== 1'b1 || inst_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL ad_flush: adel=%b req=%b addr=%h, required 0/1/00000200", if_adel_o, inst_req_o, inst_addr_o);
    end
`else
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h102 || if_adel_o !== 1'b0) begin
      errors++;
      $display("FAIL ma_passthru: req=%b addr=%h adel=%b, required 1/00000102/0", inst_req_o, inst_addr_o, if_adel_o);
    end
`endif
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ma_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch_delay_slot();
    test_stall_buffer();
    test_flush_discard();
    test_wrap();
    test_reset_midfetch();
    test_misaligned_target();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
